// File: rtl/gb_irq_pkg.sv
// +-----------------------------------------------------------------------------
// | gb_irq_pkg
// | Shared constants, register addresses and ack FSM encoding for the
// | Game Boy interrupt controller.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package gb_irq_pkg;

    localparam int NUM_IRQ = 5;

    localparam int VBLANK = 0;
    localparam int STAT   = 1;
    localparam int TIMER  = 2;
    localparam int SERIAL = 3;
    localparam int JOYPAD = 4;

    localparam logic [15:0] DEFAULT_IF_ADDR = 16'hFF0F;
    localparam logic [15:0] DEFAULT_IE_ADDR = 16'hFFFF;

    localparam logic [7:0] VECTOR_BASE   = 8'h40;
    localparam logic [7:0] VECTOR_STRIDE = 8'd8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        HOLD     = 2'd2
    } ack_state_t;

endpackage

`default_nettype wire

// File: rtl/irq_priority_encoder.sv
// +-----------------------------------------------------------------------------
// | irq_priority_encoder
// | Combinational lowest-set-bit encoder over the interrupt lines.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module irq_priority_encoder
    import gb_irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] pending,
    output logic [2:0]         idx,
    output logic               valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// +-----------------------------------------------------------------------------
// | interrupt_controller
// | IF/IE registers, request edge latching and CPU dispatch acknowledge.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module interrupt_controller
    import gb_irq_pkg::*;
#(
    parameter logic [15:0] IF_ADDR = DEFAULT_IF_ADDR,
    parameter logic [15:0] IE_ADDR = DEFAULT_IE_ADDR
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Enable,
    input  logic [15:0]        i_Address,
    input  logic [7:0]         i_Bus,
    input  logic               i_Bus_Out,
    input  logic               i_Bus_In,
    input  logic [NUM_IRQ-1:0] i_Requests,
    input  logic               i_Handle_Interrupt,
    output logic [NUM_IRQ-1:0] o_Interrupts,
    output logic [7:0]         o_Bus,
    output logic               o_Selected,
    output logic [7:0]         o_Vector,
    output logic               o_Ack_Valid
);

    logic [NUM_IRQ-1:0] if_reg;
    logic [7:0]         ie_reg;
    logic [NUM_IRQ-1:0] req_prev;
    ack_state_t         state;

    logic [NUM_IRQ-1:0] pending;
    logic [2:0]         enc_idx;
    logic               enc_valid;
    logic               if_sel;
    logic               ie_sel;
    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] ack_clear;
    logic [NUM_IRQ-1:0] if_next;

    assign pending      = if_reg & ie_reg[NUM_IRQ-1:0];
    assign o_Interrupts = pending;

    irq_priority_encoder u_encoder (
        .pending (pending),
        .idx     (enc_idx),
        .valid   (enc_valid)
    );

    assign if_sel     = (i_Address == IF_ADDR);
    assign ie_sel     = (i_Address == IE_ADDR);
    assign o_Selected = if_sel | ie_sel;

    // A fresh request edge wins over both a CPU write and an ack clear.
    always_comb begin
        edges     = i_Requests & ~req_prev;
        ack_clear = '0;
        if (state == DISPATCH && enc_valid) begin
            ack_clear = NUM_IRQ'(1) << enc_idx;
        end
        if_next = (((i_Bus_Out && if_sel) ? i_Bus[NUM_IRQ-1:0] : if_reg) & ~ack_clear) | edges;
    end

    always_comb begin
        o_Bus = 8'h00;
        if (i_Bus_In && if_sel) begin
            o_Bus = {3'b111, if_reg};
        end else if (i_Bus_In && ie_sel) begin
            o_Bus = ie_reg;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            if_reg      <= '0;
            ie_reg      <= 8'h00;
            req_prev    <= '0;
            state       <= IDLE;
            o_Vector    <= 8'h00;
            o_Ack_Valid <= 1'b0;
        end else if (i_Enable) begin
            if_reg      <= if_next;
            req_prev    <= i_Requests;
            o_Ack_Valid <= 1'b0;
            if (i_Bus_Out && ie_sel) begin
                ie_reg <= i_Bus;
            end
            case (state)
                IDLE: begin
                    if (i_Handle_Interrupt) begin
                        state <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    o_Vector    <= enc_valid ? (VECTOR_BASE + VECTOR_STRIDE * {5'd0, enc_idx}) : 8'h00;
                    o_Ack_Valid <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (!i_Handle_Interrupt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// +-----------------------------------------------------------------------------
// | tb_interrupt_controller
// | Directed vector table plus enable and reset-during-hold sequences.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_controller;

    localparam logic [15:0] IFA = 16'hFF0F;
    localparam logic [15:0] IEA = 16'hFFFF;
    localparam logic [15:0] NA  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [15:0] address = '0;
    logic [7:0]  bus = '0;
    logic        bus_out = 1'b0;
    logic        bus_in = 1'b0;
    logic [4:0]  requests = '0;
    logic        handle = 1'b0;
    logic [4:0]  interrupts;
    logic [7:0]  bus_rd;
    logic        selected;
    logic [7:0]  vector;
    logic        ack_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .i_Clk              (clk),
        .i_Reset            (rst),
        .i_Enable           (en),
        .i_Address          (address),
        .i_Bus              (bus),
        .i_Bus_Out          (bus_out),
        .i_Bus_In           (bus_in),
        .i_Requests         (requests),
        .i_Handle_Interrupt (handle),
        .o_Interrupts       (interrupts),
        .o_Bus              (bus_rd),
        .o_Selected         (selected),
        .o_Vector           (vector),
        .o_Ack_Valid        (ack_valid)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        wr;
        logic        rd;
        logic [4:0]  rq;
        logic        hs;
        logic [4:0]  e_int;
        logic [7:0]  e_bus;
        logic        e_ack;
        logic [7:0]  e_vec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] a, input logic [7:0] d, input logic wr,
                                input logic rd, input logic [4:0] rq, input logic hs,
                                input logic [4:0] e_int, input logic [7:0] e_bus,
                                input logic e_ack, input logic [7:0] e_vec);
        vec_t v;
        v.a = a; v.d = d; v.wr = wr; v.rd = rd; v.rq = rq; v.hs = hs;
        v.e_int = e_int; v.e_bus = e_bus; v.e_ack = e_ack; v.e_vec = e_vec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic wr,
                         input logic rd, input logic [4:0] rq, input logic hs);
        @(negedge clk);
        address = a; bus = d; bus_out = wr; bus_in = rd; requests = rq; handle = hs;
        #1;
    endtask

    initial begin
        bit found;

        // Each row's expectations describe the cycle in which the row is driven.
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h00, 0, 5'h00, 8'hE0, 0, 8'h00));
        vecs.push_back(mk(IEA, 8'h1F, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(IEA, 8'h00, 0, 1, 5'h04, 0, 5'h00, 8'h1F, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h04, 0, 5'h04, 8'hE4, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h04, 0, 5'h04, 8'hE4, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h04, 0, 5'h04, 8'hE4, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h04, 0, 5'h04, 8'hE4, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 1, 1, 5'h04, 0, 5'h04, 8'hE4, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h04, 0, 5'h00, 8'hE0, 0, 8'h00));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h16, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h00, 1, 5'h16, 8'hF6, 0, 8'h00));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 1, 5'h16, 8'h00, 0, 8'h00));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 1, 5'h14, 8'h00, 1, 8'h48));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h14, 8'h00, 0, 8'h48));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 1, 5'h14, 8'h00, 0, 8'h48));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h14, 8'h00, 0, 8'h48));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h10, 8'h00, 1, 8'h50));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 1, 5'h10, 8'h00, 0, 8'h50));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h10, 8'h00, 0, 8'h50));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h00, 8'h00, 1, 8'h60));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h60));
        vecs.push_back(mk(IFA, 8'h01, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h60));
        vecs.push_back(mk(IEA, 8'h00, 1, 0, 5'h00, 1, 5'h01, 8'h00, 0, 8'h60));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h60));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h00, 0, 5'h00, 8'hE1, 1, 8'h00));
        vecs.push_back(mk(IEA, 8'h1F, 1, 0, 5'h00, 0, 5'h00, 8'h00, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 1, 0, 5'h04, 0, 5'h01, 8'h00, 0, 8'h00));
        vecs.push_back(mk(IFA, 8'h00, 0, 1, 5'h04, 0, 5'h04, 8'hE4, 0, 8'h00));
        vecs.push_back(mk(NA,  8'h00, 0, 0, 5'h00, 0, 5'h04, 8'h00, 0, 8'h00));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].d, vecs[i].wr, vecs[i].rd, vecs[i].rq, vecs[i].hs);
            chk($sformatf("row%0d int", i), 32'(interrupts), 32'(vecs[i].e_int));
            chk($sformatf("row%0d bus", i), 32'(bus_rd), 32'(vecs[i].e_bus));
            chk($sformatf("row%0d ack", i), 32'(ack_valid), 32'(vecs[i].e_ack));
            chk($sformatf("row%0d vec", i), 32'(vector), 32'(vecs[i].e_vec));
            chk($sformatf("row%0d sel", i), 32'(selected),
                32'((vecs[i].a == IFA) || (vecs[i].a == IEA)));
        end

        // Clock enable low: writes and request edges must be ignored.
        en = 1'b0;
        drive(IFA, 8'h1F, 1, 0, 5'h02, 0);
        drive(IFA, 8'h00, 0, 1, 5'h02, 0);
        chk("dis int", 32'(interrupts), 32'h04);
        chk("dis bus", 32'(bus_rd), 32'hE4);
        drive(NA, 8'h00, 0, 0, 5'h00, 0);
        en = 1'b1;
        drive(IFA, 8'h00, 0, 1, 5'h00, 0);
        chk("reen int", 32'(interrupts), 32'h04);
        chk("reen bus", 32'(bus_rd), 32'hE4);

        // Reset while the FSM sits in HOLD with every IF bit set.
        drive(IFA, 8'h1F, 1, 0, 5'h00, 0);
        drive(NA,  8'h00, 0, 0, 5'h00, 1);
        drive(NA,  8'h00, 0, 0, 5'h00, 1);
        drive(IFA, 8'h1F, 1, 0, 5'h00, 1);
        chk("pre ack", 32'(ack_valid), 32'h1);
        chk("pre vec", 32'(vector), 32'h40);
        drive(NA,  8'h00, 0, 0, 5'h00, 1);
        chk("hold int", 32'(interrupts), 32'h1F);
        rst = 1'b1;
        #1;
        chk("rst int", 32'(interrupts), 32'h00);
        chk("rst ack", 32'(ack_valid), 32'h0);
        chk("rst vec", 32'(vector), 32'h00);
        address = IFA; bus_in = 1'b1; #1;
        chk("rst if", 32'(bus_rd), 32'hE0);
        address = IEA; #1;
        chk("rst ie", 32'(bus_rd), 32'h00);
        drive(NA, 8'h00, 0, 0, 5'h00, 0);
        rst = 1'b0;
        drive(IEA, 8'h1F, 1, 0, 5'h00, 0);
        drive(IFA, 8'h08, 1, 0, 5'h00, 0);
        drive(NA,  8'h00, 0, 0, 5'h00, 1);
        chk("post int", 32'(interrupts), 32'h08);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            drive(NA, 8'h00, 0, 0, 5'h00, 1);
            if (ack_valid === 1'b1) begin
                found = 1'b1;
                chk("post vec", 32'(vector), 32'h58);
            end
        end
        chk("post ack seen", 32'(found), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
